// File: rtl/div_iter_responder_pkg.sv
// Shared types and constants for the iterative restoring divider.
// Also holds the final sign fix / result select applied on entry to DONE.
package div_iter_responder_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned DIV_ITER_D = 64;
  localparam int unsigned DIV_ITER_W = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  function automatic logic [XLEN-1:0] div_fix_result(input logic [XLEN-1:0] quot,
                                                     input logic [XLEN-1:0] rem,
                                                     input logic            neg_quot,
                                                     input logic            neg_rem,
                                                     input logic            get_div,
                                                     input logic            is_word);
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    logic [XLEN-1:0] res;
    q_fix = neg_quot ? -quot : quot;
    r_fix = neg_rem ? -rem : rem;
    res   = get_div ? q_fix : r_fix;
    // W results are always sign-extended from bit 31, even for the unsigned forms
    if (is_word) begin
      res = {{(XLEN/2){res[XLEN/2-1]}}, res[XLEN/2-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit,
// subtract the divisor if it fits and record the quotient bit.
module div_step
  import div_iter_responder_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quot,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quot_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    shifted = {rem, quot[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    // No borrow out of the 65-bit subtraction means shifted >= divisor
    if (!diff[XLEN]) begin
      rem_next  = diff[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b1};
    end else begin
      rem_next  = shifted[XLEN-1:0];
      quot_next = {quot[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_iter_responder.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and W variants.
// Accepts a request in IDLE, iterates in CALC, pulses resp_valid in DONE.
module div_iter_responder
  import div_iter_responder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            is_signed,
  input  logic            get_div,
  input  logic            is_word,
  output logic            resp_valid,
  output logic [XLEN-1:0] c
);

  localparam int unsigned Half = XLEN / 2;

  div_state_t      state_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] c_q;
  logic [6:0]      cnt_q;
  logic            neg_quot_q;
  logic            neg_rem_q;
  logic            get_div_q;
  logic            is_word_q;

  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] min_neg;
  logic [XLEN-1:0] special_quot;
  logic [XLEN-1:0] special_rem;
  logic [6:0]      iter_n;
  logic            neg_quot;
  logic            neg_rem;
  logic            b_neg;
  logic            div_by_zero;
  logic            overflow;

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quot;

  always_comb begin
    if (is_word) begin
      a_ext   = {{Half{is_signed & a[Half-1]}}, a[Half-1:0]};
      b_ext   = {{Half{is_signed & b[Half-1]}}, b[Half-1:0]};
      min_neg = {{(Half+1){1'b1}}, {(Half-1){1'b0}}};
      iter_n  = 7'(DIV_ITER_W);
    end else begin
      a_ext   = a;
      b_ext   = b;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
      iter_n  = 7'(DIV_ITER_D);
    end
    neg_rem  = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    neg_quot = neg_rem ^ b_neg;
    a_abs    = neg_rem ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    // W dividends sit in the top half so 32 steps shift them fully through
    dividend = is_word ? {a_abs[Half-1:0], {Half{1'b0}}} : a_abs;

    div_by_zero  = (b_ext == '0);
    overflow     = is_signed & (a_ext == min_neg) & (&b_ext);
    special_quot = div_by_zero ? '1 : a_ext;
    special_rem  = div_by_zero ? a_ext : '0;
  end

  div_step u_div_step (
    .rem       (rem_q),
    .quot      (quot_q),
    .divisor   (divisor_q),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      quot_q     <= '0;
      rem_q      <= '0;
      divisor_q  <= '0;
      c_q        <= '0;
      cnt_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      get_div_q  <= 1'b0;
      is_word_q  <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            get_div_q <= get_div;
            is_word_q <= is_word;
            if (div_by_zero || overflow) begin
              neg_quot_q <= 1'b0;
              neg_rem_q  <= 1'b0;
              c_q        <= div_fix_result(special_quot, special_rem, 1'b0, 1'b0,
                                           get_div, is_word);
              state_q    <= DONE;
            end else begin
              neg_quot_q <= neg_quot;
              neg_rem_q  <= neg_rem;
              quot_q     <= dividend;
              rem_q      <= '0;
              divisor_q  <= b_abs;
              cnt_q      <= iter_n;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          quot_q <= step_quot;
          rem_q  <= step_rem;
          cnt_q  <= cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            c_q     <= div_fix_result(step_quot, step_rem, neg_quot_q, neg_rem_q,
                                      get_div_q, is_word_q);
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) & ~flush;
  assign resp_valid = (state_q == DONE) & ~flush;
  assign c          = c_q;

endmodule

// File: tb/tb_div_iter_responder.sv
// Directed bench for div_iter_responder: vector table plus flush/reset sequences.
module tb_div_iter_responder;

  typedef struct {
    string       name;
    logic [63:0] a;
    logic [63:0] b;
    logic        sg;
    logic        dv;
    logic        wd;
    logic [63:0] exp_c;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        is_signed = 1'b0;
  logic        get_div = 1'b0;
  logic        is_word = 1'b0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] c;

  int n_cmp = 0;
  int n_fail = 0;

  vec_t vecs[15];

  always #5 clk = ~clk;

  div_iter_responder dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .a          (a),
    .b          (b),
    .is_signed  (is_signed),
    .get_div    (get_div),
    .is_word    (is_word),
    .resp_valid (resp_valid),
    .c          (c)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [63:0] va, input logic [63:0] vb, input logic sg,
                       input logic dv, input logic wd);
    a         = va;
    b         = vb;
    is_signed = sg;
    get_div   = dv;
    is_word   = wd;
    req_valid = 1'b1;
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    a         = {$urandom, $urandom};
    b         = {$urandom, $urandom};
    is_signed = 1'($urandom);
    get_div   = 1'($urandom);
    is_word   = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge after the response cycle.
  task automatic run_vec(input vec_t v);
    int n;
    int lat;
    logic ready_busy;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    drive(v.a, v.b, v.sg, v.dv, v.wd);
    @(negedge clk);
    scramble();
    lat = 1;
    ready_busy = 1'b0;
    while (!resp_valid && lat < 200) begin
      if (req_ready) ready_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({v.name, "_lat"}, 64'(lat), 64'(v.lat));
    check({v.name, "_c"}, c, v.exp_c);
    check({v.name, "_ready_busy"}, 64'(ready_busy), 64'd0);
    @(negedge clk);
    check({v.name, "_resp_drop"}, 64'(resp_valid), 64'd0);
    check({v.name, "_ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    vec_t v;
    logic seen;

    vecs[0]  = '{"divu_100_7", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd14, 65};
    vecs[1]  = '{"remu_100_7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd2, 65};
    vecs[2]  = '{"div_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFD, 65};
    vecs[3]  = '{"rem_m7_2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 65};
    vecs[4]  = '{"divu_by0", 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[5]  = '{"rem_by0", 64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, 64'h1234, 1};
    vecs[6]  = '{"div_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
                 64'h8000_0000_0000_0000, 1};
    vecs[7]  = '{"rem_ovf", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0,
                 64'd0, 1};
    vecs[8]  = '{"divuw_big", 64'hDEAD_BEEF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[9]  = '{"divw_ovf", 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b1,
                 64'hFFFF_FFFF_8000_0000, 1};
    vecs[10] = '{"remw_m7_2", 64'h1234_5678_FFFF_FFF9, 64'hAAAA_0000_0000_0002, 1'b1, 1'b0, 1'b1,
                 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vecs[11] = '{"divuw_16_3", 64'h0000_0001_0000_0010, 64'h0000_0005_0000_0003, 1'b0, 1'b1, 1'b1,
                 64'd5, 33};
    vecs[12] = '{"remuw_by0", 64'hABCD_0000_8000_0001, 64'hFFFF_0000_0000_0000, 1'b0, 1'b0, 1'b1,
                 64'hFFFF_FFFF_8000_0001, 1};
    vecs[13] = '{"div_max_m2", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b1, 1'b0,
                 64'hC000_0000_0000_0001, 65};
    vecs[14] = '{"divu_ones_16", 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 1'b0, 1'b1, 1'b0,
                 64'h0FFF_FFFF_FFFF_FFFF, 65};

    repeat (3) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_c", c, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      run_vec(vecs[i]);
    end

    // Flush in the DONE cycle suppresses the response pulse
    drive(64'd5, 64'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    scramble();
    flush = 1'b1;
    #1;
    check("flush_done_resp", 64'(resp_valid), 64'd0);
    check("flush_done_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_done_resp2", 64'(resp_valid), 64'd0);
    check("flush_done_ready2", 64'(req_ready), 64'd1);

    // A request presented alongside flush is not taken
    @(negedge clk);
    drive(64'd5, 64'd0, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    scramble();
    flush = 1'b0;
    #1;
    check("flush_req_noresp", 64'(resp_valid), 64'd0);
    check("flush_req_ready2", 64'(req_ready), 64'd1);

    // Flush at T+10 of a DIVU, then a fresh request at T+11
    @(negedge clk);
    drive(64'd1000, 64'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    scramble();
    seen = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (resp_valid) seen = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    if (resp_valid) seen = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_calc_noresp", 64'(seen | resp_valid), 64'd0);
    check("flush_calc_ready", 64'(req_ready), 64'd1);
    v = '{"after_flush", 64'd100, 64'd7, 1'b0, 1'b1, 1'b0, 64'd14, 65};
    run_vec(v);

    // Asynchronous reset at T+20 clears c and aborts without a response
    drive(64'd1000, 64'd10, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    scramble();
    repeat (19) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("arst_resp", 64'(resp_valid), 64'd0);
    check("arst_c", c, 64'd0);
    check("arst_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("arst_noresp", 64'(seen), 64'd0);
    v = '{"after_reset", 64'd1000, 64'd10, 1'b0, 1'b1, 1'b0, 64'd100, 65};
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
